// File: rtl/counting_sorter_pipe_pkg.sv
// ---------------------------------------------------------------------------
// counting_sorter_pkg
// Shared definitions for the pipelined counting sorter.
//   state_e : top-level controller states
//   sat_inc : saturating increment of a counter of a given width
// Optional build macro honoured by the sorter: COUNTING_SORTER_RANGE_EN
// ---------------------------------------------------------------------------
package counting_sorter_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    LOAD       = 3'd2,
    SCAN_REQ   = 3'd3,
    SCAN_CHECK = 3'd4,
    EMIT       = 3'd5,
    DONE       = 3'd6
  } state_e;

  // Increments value unless it already equals the all-ones pattern of
  // 'width' bits, in which case it holds. Valid for widths up to 31.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] maxVal;
    maxVal = (32'd1 << width) - 32'd1;
    return (value == maxVal) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/counting_sorter_pipe_ram.sv
// ---------------------------------------------------------------------------
// ram_1r1w_sync
// Simple dual-port RAM: one synchronous write port, one synchronous read
// port. A read and a write to the same address in one cycle returns the
// old contents. Contents are not reset.
// Ports:
//   i_clk    clock, rising edge
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address (registered data appears next cycle)
//   o_rdata  read data
// ---------------------------------------------------------------------------
module ram_1r1w_sync
  import counting_sorter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [WIDTH-1:0] r_rdata;

  // Read and write share one block so a colliding read sees the old word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/counting_sorter_pipe.sv
// ---------------------------------------------------------------------------
// counting_sorter_pipe
// Counting sorter: clears a histogram table, loads length_i keys at one key
// per cycle (read-modify-write with forwarding), then scans the table and
// streams the keys back in ascending or descending order.
// Ports:
//   clk_i, reset_i (sync, active high)
//   start_i, descending_i, length_i      : sort command (IDLE/DONE only)
//   value_i, value_valid_i, value_ready_o: key input stream
//   sorted_value_o, sorted_valid_o, sorted_ready_i, sorted_last_o: output
//   busy_o, done_o, overflow_o (sticky bucket saturation)
// Build macro: COUNTING_SORTER_RANGE_EN limits the scan to [min,max] of the
// loaded keys; without it the whole bucket range is scanned.
// ---------------------------------------------------------------------------
module counting_sorter_pipe
  import counting_sorter_pkg::*;
#(
  parameter int VALUE_WIDTH = 10,
  parameter int COUNT_WIDTH = 16,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   descending_i,
  input  logic [LEN_WIDTH-1:0]   length_i,
  input  logic [VALUE_WIDTH-1:0] value_i,
  input  logic                   value_valid_i,
  output logic                   value_ready_o,
  output logic [VALUE_WIDTH-1:0] sorted_value_o,
  output logic                   sorted_valid_o,
  input  logic                   sorted_ready_i,
  output logic                   sorted_last_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o
);

  localparam logic [VALUE_WIDTH-1:0] LAST_BUCKET = '1;

  state_e                 r_state;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [LEN_WIDTH-1:0]   r_accepted;
  logic [LEN_WIDTH-1:0]   r_written;
  logic [LEN_WIDTH-1:0]   r_emitted;
  logic                   r_desc;
  logic                   r_overflow;
  logic [VALUE_WIDTH-1:0] r_clrAddr;
  logic [VALUE_WIDTH-1:0] r_scanAddr;
  logic [COUNT_WIDTH-1:0] r_rem;

  // Load pipeline: read issued on handshake, write one cycle later.
  logic                   r_rdPending;
  logic [VALUE_WIDTH-1:0] r_rdAddr;
  logic                   r_fwdValid;
  logic [VALUE_WIDTH-1:0] r_fwdAddr;
  logic [COUNT_WIDTH-1:0] r_fwdData;

  logic                   w_loadHs;
  logic                   w_emitHs;
  logic [COUNT_WIDTH-1:0] w_ramRdata;
  logic [COUNT_WIDTH-1:0] w_old;
  logic [COUNT_WIDTH-1:0] w_newCount;
  logic                   w_oldFull;
  logic                   w_lastWrite;
  logic [LEN_WIDTH-1:0]   w_emittedNext;
  logic [VALUE_WIDTH-1:0] w_scanFirst;
  logic [VALUE_WIDTH-1:0] w_scanLast;
  logic [VALUE_WIDTH-1:0] w_scanStep;
  logic                   w_ramWe;
  logic [VALUE_WIDTH-1:0] w_ramWaddr;
  logic [COUNT_WIDTH-1:0] w_ramWdata;
  logic [VALUE_WIDTH-1:0] w_ramRaddr;

  assign value_ready_o = (r_state == LOAD) && (r_accepted < r_len);
  assign w_loadHs      = value_valid_i && value_ready_o;
  assign w_emitHs      = (r_state == EMIT) && sorted_ready_i;

  // The RAM cannot see last cycle's write yet, so a back-to-back repeat of
  // the same key takes its count from the forwarding register instead.
  assign w_old       = (r_fwdValid && (r_fwdAddr == r_rdAddr)) ? r_fwdData : w_ramRdata;
  assign w_oldFull   = (w_old == '1);
  assign w_newCount  = COUNT_WIDTH'(sat_inc(32'(w_old), COUNT_WIDTH));
  assign w_lastWrite = r_rdPending && (r_written == (r_len - LEN_WIDTH'(1)));

  assign w_emittedNext = r_emitted + LEN_WIDTH'(1);
  assign w_scanStep    = r_desc ? (r_scanAddr - VALUE_WIDTH'(1))
                                : (r_scanAddr + VALUE_WIDTH'(1));

`ifdef COUNTING_SORTER_RANGE_EN
  logic [VALUE_WIDTH-1:0] r_min;
  logic [VALUE_WIDTH-1:0] r_max;

  assign w_scanFirst = r_desc ? r_max : r_min;
  assign w_scanLast  = r_desc ? r_min : r_max;

  // Track the key range seen during load so the scan skips empty ends.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_min <= '0;
      r_max <= '0;
    end else if (((r_state == IDLE) || (r_state == DONE)) && start_i) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_loadHs) begin
      if (value_i < r_min) r_min <= value_i;
      if (value_i > r_max) r_max <= value_i;
    end
  end
`else
  assign w_scanFirst = r_desc ? LAST_BUCKET : '0;
  assign w_scanLast  = r_desc ? '0 : LAST_BUCKET;
`endif

  // Single RAM write port is shared by the clear sweep and the load RMW;
  // the read port serves load lookups and scan reads.
  always_comb begin
    w_ramWe    = 1'b0;
    w_ramWaddr = r_clrAddr;
    w_ramWdata = '0;
    if (r_state == CLEAR) begin
      w_ramWe = 1'b1;
    end else if (r_rdPending) begin
      w_ramWe    = 1'b1;
      w_ramWaddr = r_rdAddr;
      w_ramWdata = w_newCount;
    end
    w_ramRaddr = (r_state == SCAN_REQ) ? r_scanAddr : value_i;
  end

  ram_1r1w_sync #(
    .WIDTH      (COUNT_WIDTH),
    .DEPTH_LOG2 (VALUE_WIDTH)
  ) u_countRam (
    .i_clk   (clk_i),
    .i_we    (w_ramWe),
    .i_waddr (w_ramWaddr),
    .i_wdata (w_ramWdata),
    .i_raddr (w_ramRaddr),
    .o_rdata (w_ramRdata)
  );

  // Load pipeline registers; they only carry state within one LOAD phase.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rdPending <= 1'b0;
      r_rdAddr    <= '0;
      r_fwdValid  <= 1'b0;
      r_fwdAddr   <= '0;
      r_fwdData   <= '0;
    end else begin
      r_rdPending <= w_loadHs;
      r_rdAddr    <= value_i;
      r_fwdValid  <= r_rdPending;
      r_fwdAddr   <= r_rdAddr;
      r_fwdData   <= w_newCount;
    end
  end

  // Main controller: clear, load, then scan/emit until the stream ends.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_desc     <= 1'b0;
      r_overflow <= 1'b0;
      r_clrAddr  <= '0;
      r_scanAddr <= '0;
      r_rem      <= '0;
      r_accepted <= '0;
      r_written  <= '0;
      r_emitted  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start_i) begin
            r_state    <= CLEAR;
            r_len      <= length_i;
            r_desc     <= descending_i;
            r_overflow <= 1'b0;
            r_clrAddr  <= '0;
            r_accepted <= '0;
            r_written  <= '0;
            r_emitted  <= '0;
          end
        end
        CLEAR: begin
          r_clrAddr <= r_clrAddr + VALUE_WIDTH'(1);
          if (r_clrAddr == LAST_BUCKET) begin
            r_state <= (r_len == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (w_loadHs) begin
            r_accepted <= r_accepted + LEN_WIDTH'(1);
          end
          if (r_rdPending) begin
            r_written <= r_written + LEN_WIDTH'(1);
            if (w_oldFull) begin
              r_overflow <= 1'b1;
            end
          end
          // The last write lands at this edge, so the scan read next cycle
          // already observes it.
          if (w_lastWrite) begin
            r_state    <= SCAN_REQ;
            r_scanAddr <= w_scanFirst;
          end
        end
        SCAN_REQ: begin
          r_state <= SCAN_CHECK;
        end
        SCAN_CHECK: begin
          if (w_ramRdata != '0) begin
            r_rem   <= w_ramRdata;
            r_state <= EMIT;
          end else if (r_scanAddr == w_scanLast) begin
            r_state <= DONE;
          end else begin
            r_scanAddr <= w_scanStep;
            r_state    <= SCAN_REQ;
          end
        end
        EMIT: begin
          if (w_emitHs) begin
            r_rem     <= r_rem - COUNT_WIDTH'(1);
            r_emitted <= w_emittedNext;
            // Early exit once every key is out, so trailing empty buckets
            // are never scanned.
            if (r_rem == COUNT_WIDTH'(1)) begin
              if ((r_scanAddr == w_scanLast) || (w_emittedNext == r_len)) begin
                r_state <= DONE;
              end else begin
                r_scanAddr <= w_scanStep;
                r_state    <= SCAN_REQ;
              end
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sorted_valid_o = (r_state == EMIT);
  assign sorted_value_o = sorted_valid_o ? r_scanAddr : '0;
  assign sorted_last_o  = sorted_valid_o && (w_emittedNext == r_len);
  assign busy_o         = (r_state != IDLE);
  assign done_o         = (r_state == DONE);
  assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_counting_sorter_pipe.sv
// ---------------------------------------------------------------------------
// tb_counting_sorter_pipe
// Directed bench for the counting sorter. Two instances share all inputs:
// dutA uses 16-bit counts, dutB uses 2-bit counts so saturation is easy to
// reach. Both use 4-bit keys (16 buckets).
// ---------------------------------------------------------------------------
module tb_counting_sorter_pipe;

`ifdef COUNTING_SORTER_RANGE_EN
  localparam int SCAN_WAIT_456 = 3;
`else
  localparam int SCAN_WAIT_456 = 11;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        desc;
  logic [15:0] lengthIn;
  logic [3:0]  valueIn;
  logic        valueValid;
  logic        sortedReady;

  logic       readyA, validA, lastA, busyA, doneA, ovfA;
  logic [3:0] valA;
  logic       readyB, validB, lastB, busyB, doneB, ovfB;
  logic [3:0] valB;

  int checkCount = 0;
  int errorCount = 0;

  int feedKeys[$];
  int gotVals[$];
  int lastIdx;
  int lastCount;
  int firstWait;
  int doneGap;
  int stalls;

  // Free-running clock
  always #5 clk = ~clk;

  counting_sorter_pipe #(.VALUE_WIDTH(4), .COUNT_WIDTH(16), .LEN_WIDTH(16)) dutA (
    .clk_i(clk), .reset_i(reset), .start_i(start), .descending_i(desc),
    .length_i(lengthIn), .value_i(valueIn), .value_valid_i(valueValid),
    .value_ready_o(readyA), .sorted_value_o(valA), .sorted_valid_o(validA),
    .sorted_ready_i(sortedReady), .sorted_last_o(lastA), .busy_o(busyA),
    .done_o(doneA), .overflow_o(ovfA)
  );

  counting_sorter_pipe #(.VALUE_WIDTH(4), .COUNT_WIDTH(2), .LEN_WIDTH(16)) dutB (
    .clk_i(clk), .reset_i(reset), .start_i(start), .descending_i(desc),
    .length_i(lengthIn), .value_i(valueIn), .value_valid_i(valueValid),
    .value_ready_o(readyB), .sorted_value_o(valB), .sorted_valid_o(validB),
    .sorted_ready_i(sortedReady), .sorted_last_o(lastB), .busy_o(busyB),
    .done_o(doneB), .overflow_o(ovfB)
  );

  // Every comparison goes through here and is counted
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Wait until neither instance is mid-sort
  task automatic waitIdle(input string tag);
    int cyc = 0;
    sortedReady = 1'b1;
    while (((busyA && !doneA) || (busyB && !doneB)) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput({tag, "_idleTimeout"}, 32'(cyc >= 3000), 0);
  endtask

  task automatic startSort(input string tag, input int len, input bit descending);
    waitIdle(tag);
    lengthIn = len[15:0];
    desc     = descending;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Start a sort and push feedKeys, counting stall cycles after the first key
  task automatic applyStimulus(input string tag, input bit descending);
    int  i = 0;
    int  cyc = 0;
    bit  hs;
    bit  started = 0;
    startSort(tag, feedKeys.size(), descending);
    stalls = 0;
    while (i < feedKeys.size() && cyc < 500) begin
      valueIn    = 4'(feedKeys[i]);
      valueValid = 1'b1;
      hs         = readyA;
      if (started && !hs) stalls++;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        started = 1;
        i++;
      end
    end
    valueValid = 1'b0;
    checkOutput({tag, "_feedTimeout"}, 32'(i < feedKeys.size()), 0);
  endtask

  // Drain the output stream of one instance until done or maxOut handshakes
  task automatic collectOutput(input string tag, input bit selB,
                               input bit throttle, input int maxOut);
    int cyc = 0;
    int lastHs = -1;
    bit v, l, d;
    int val;
    gotVals.delete();
    lastIdx = -1; lastCount = 0; firstWait = -1; doneGap = -1;
    while (cyc < 2000) begin
      d = selB ? doneB : doneA;
      if (d) begin
        doneGap = cyc - lastHs;
        break;
      end
      if (gotVals.size() >= maxOut) break;
      sortedReady = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      v   = selB ? validB : validA;
      l   = selB ? lastB : lastA;
      val = int'(selB ? valB : valA);
      if (v && firstWait < 0) firstWait = cyc;
      if (v && sortedReady) begin
        if (l) begin
          if (lastIdx < 0) lastIdx = gotVals.size();
          lastCount++;
        end
        gotVals.push_back(val);
        lastHs = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    sortedReady = 1'b1;
    checkOutput({tag, "_collectTimeout"}, 32'(cyc >= 2000), 0);
  endtask

  // Compare the collected stream and its last flag to hand-computed values
  task automatic compareStream(input string tag, input int expVals[$],
                               input int expLastIdx);
    checkOutput({tag, "_count"}, 32'(gotVals.size()), 32'(expVals.size()));
    for (int i = 0; i < expVals.size(); i++) begin
      checkOutput($sformatf("%s_val%0d", tag, i),
                  (i < gotVals.size()) ? 32'(gotVals[i]) : 32'hFFFF, 32'(expVals[i]));
    end
    checkOutput({tag, "_lastIdx"}, 32'(lastIdx), 32'(expLastIdx));
    checkOutput({tag, "_lastCount"}, 32'(lastCount), (expLastIdx >= 0) ? 32'd1 : 32'd0);
  endtask

  // Directed test sequence
  initial begin
    bit seenReady, seenValid;
    int doneAt;

    reset = 1'b1; start = 1'b0; desc = 1'b0; lengthIn = '0;
    valueIn = '0; valueValid = 1'b0; sortedReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_outA", 32'({readyA, validA, valA, lastA, busyA, doneA, ovfA}), 0);
    checkOutput("reset_outB", 32'({readyB, validB, valB, lastB, busyB, doneB, ovfB}), 0);

    // Test 1: ascending mixed keys
    feedKeys = '{5, 1, 5, 0, 15, 1};
    applyStimulus("t1", 1'b0);
    collectOutput("t1", 1'b0, 1'b0, 100);
    compareStream("t1", '{0, 1, 1, 5, 5, 15}, 5);
    checkOutput("t1_firstWait", 32'(firstWait), 3);
    checkOutput("t1_doneGap", 32'(doneGap), 1);

    // Test 2: same keys descending, no load stalls
    applyStimulus("t2", 1'b1);
    checkOutput("t2_stalls", 32'(stalls), 0);
    collectOutput("t2", 1'b0, 1'b0, 100);
    compareStream("t2", '{15, 5, 5, 1, 1, 0}, 5);
    checkOutput("t2_doneGap", 32'(doneGap), 1);

    // Test 3: repeated key back-to-back exercises forwarding
    feedKeys = '{7, 7, 7, 7, 7, 7, 7, 7};
    applyStimulus("t3", 1'b0);
    checkOutput("t3_stalls", 32'(stalls), 0);
    collectOutput("t3", 1'b0, 1'b0, 100);
    compareStream("t3", '{7, 7, 7, 7, 7, 7, 7, 7}, 7);
    checkOutput("t3_ovfA", 32'(ovfA), 0);

    // Test 4: 2-bit counts saturate at 3
    feedKeys = '{3, 3, 3, 3, 3};
    applyStimulus("t4", 1'b0);
    collectOutput("t4", 1'b1, 1'b0, 100);
    compareStream("t4", '{3, 3, 3}, -1);
    checkOutput("t4_ovfB", 32'(ovfB), 1);
    checkOutput("t4_doneB", 32'(doneB), 1);
    checkOutput("t4_ovfA", 32'(ovfA), 0);

    // Test 5: zero-length sort clears then finishes, overflow flag cleared
    startSort("t5", 0, 1'b0);
    checkOutput("t5_ovfBCleared", 32'(ovfB), 0);
    seenReady = 0; seenValid = 0; doneAt = -1;
    for (int c = 0; c < 100; c++) begin
      seenReady |= readyA;
      seenValid |= validA;
      if (doneA) begin
        doneAt = c;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("t5_doneAt", 32'(doneAt), 16);
    checkOutput("t5_noReady", 32'(seenReady), 0);
    checkOutput("t5_noValid", 32'(seenValid), 0);

    // Test 6: throttled output, reset mid-emit, then a clean restart
    feedKeys = '{9, 2, 13, 2, 7, 0, 11, 7, 14, 3};
    applyStimulus("t6a", 1'b0);
    collectOutput("t6a", 1'b0, 1'b1, 2);
    checkOutput("t6a_val0", (gotVals.size() > 0) ? 32'(gotVals[0]) : 32'hFFFF, 0);
    checkOutput("t6a_val1", (gotVals.size() > 1) ? 32'(gotVals[1]) : 32'hFFFF, 2);
    checkOutput("t6a_midValid", 32'(validA), 1);
    checkOutput("t6a_midValue", 32'(valA), 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("t6_resetOutA", 32'({readyA, validA, valA, lastA, busyA, doneA, ovfA}), 0);
    checkOutput("t6_resetOutB", 32'({readyB, validB, valB, lastB, busyB, doneB, ovfB}), 0);
    feedKeys = '{4, 5, 6};
    applyStimulus("t6b", 1'b0);
    collectOutput("t6b", 1'b0, 1'b0, 100);
    compareStream("t6b", '{4, 5, 6}, 2);
    checkOutput("t6b_firstWait", 32'(firstWait), 32'(SCAN_WAIT_456));
    checkOutput("t6b_doneGap", 32'(doneGap), 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
